// File: rtl/rr_mux2_stage.sv
// Registered two-input round-robin arbitration stage: merges two valid/ready
// streams into one registered output stream and tags each word with its source.
module rr_mux2_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             can_load_s;
    logic             grant_valid_s;
    logic             grant_s;
    logic [WIDTH-1:0] grant_data_s;
    logic             last_grant_r;

    // Arbitration: lone requester wins, contention goes to the source not served last.
    always_comb begin
        can_load_s    = !out_valid || out_ready;
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        case ({in1_valid, in0_valid})
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_s       = ~last_grant_r;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_s       = 1'b0;
            end
        endcase
        grant_data_s = grant_s ? in1_data : in0_data;
    end

    // Ready generation; gated by reset_n so nothing is accepted while in reset.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (reset_n && can_load_s && grant_valid_s) begin
            in0_ready = ~grant_s;
            in1_ready = grant_s;
        end else begin
            in0_ready = 1'b0;
            in1_ready = 1'b0;
        end
    end

    // Output register and round-robin pointer; pointer moves only on a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data     <= {WIDTH{1'b0}};
            out_src      <= 1'b0;
            out_valid    <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (can_load_s && grant_valid_s) begin
            out_data     <= grant_data_s;
            out_src      <= grant_s;
            out_valid    <= 1'b1;
            last_grant_r <= grant_s;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end else begin
            out_valid    <= out_valid;
        end
    end

endmodule

// File: tb/tb_rr_mux2_stage.sv
// Directed plus randomized bench for rr_mux2_stage against a queue-free
// behavioural model that tracks "who is preferred next" rather than last grant.
module tb_rr_mux2_stage;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in0_data, in1_data, out_data;
    logic         in0_valid, in1_valid, in0_ready, in1_ready;
    logic         out_src, out_valid, out_ready;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] m_data;
    logic         m_src;
    logic         m_valid;
    int           pref;

    always #5 clk = ~clk;

    rr_mux2_stage #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_data  = '0;
        m_src   = 1'b0;
        m_valid = 1'b0;
        pref    = 0;
    endfunction

    // Check readies and outputs for the current inputs, then advance one clock.
    task automatic step(input string tag);
        bit can_load, gv;
        int g;
        #1;
        can_load = !m_valid || out_ready;
        gv = in0_valid || in1_valid;
        if (in0_valid && in1_valid) g = pref;
        else if (in1_valid)         g = 1;
        else                        g = 0;
        chk({tag, ".in0_ready"}, in0_ready, (can_load && gv && g == 0));
        chk({tag, ".in1_ready"}, in1_ready, (can_load && gv && g == 1));
        chk({tag, ".out_valid"}, out_valid, m_valid);
        chk({tag, ".out_data"},  out_data,  m_data);
        chk({tag, ".out_src"},   out_src,   m_src);
        @(posedge clk);
        if (can_load && gv) begin
            m_data  = (g == 1) ? in1_data : in0_data;
            m_src   = (g == 1);
            m_valid = 1'b1;
            pref    = 1 - g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic v0, input logic [W-1:0] d0,
                          input logic v1, input logic [W-1:0] d1, input logic ordy);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        out_ready = ordy;
    endtask

    // Asynchronous reset between clock edges, checked before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, ".rst_valid"}, out_valid, 1'b0);
        chk({tag, ".rst_data"},  out_data,  16'h0000);
        chk({tag, ".rst_src"},   out_src,   1'b0);
        chk({tag, ".rst_rdy0"},  in0_ready, 1'b0);
        chk({tag, ".rst_rdy1"},  in1_ready, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic exp_src [4];
        exp_src[0] = 1'b0; exp_src[1] = 1'b1; exp_src[2] = 1'b0; exp_src[3] = 1'b1;
        reset_n = 1'b0;
        set_in(1'b1, 16'h1234, 1'b1, 16'h5678, 1'b1);
        model_reset();
        #3;
        chk("por.valid", out_valid, 1'b0);
        chk("por.rdy0", in0_ready, 1'b0);
        chk("por.rdy1", in1_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single source
        set_in(1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b1);
        step("single");
        chk("single.data", out_data, 16'hA5A5);
        chk("single.src", out_src, 1'b0);
        chk("single.valid", out_valid, 1'b1);

        // Contention right after reset: 0,1,0,1
        async_reset("mid");
        set_in(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("contend");
            chk("contend.src", out_src, exp_src[i]);
            chk("contend.data", out_data, exp_src[i] ? 16'h2222 : 16'h1111);
        end

        // Backpressure with BEEF frozen in the register
        set_in(1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b1);
        step("bp_load");
        set_in(1'b1, 16'h3333, 1'b1, 16'h4444, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("bp_stall");
            chk("bp.data", out_data, 16'hBEEF);
        end
        out_ready = 1'b1;
        step("bp_release");
        chk("bp.next_src", out_src, 1'b1);
        chk("bp.next_data", out_data, 16'h4444);

        // Priority retention across idle cycles, then drain hold
        async_reset("prio");
        set_in(1'b0, 16'h0000, 1'b1, 16'h00FF, 1'b1);
        step("prio_in1");
        set_in(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        step("idle1");
        chk("drain.valid", out_valid, 1'b0);
        chk("drain.data", out_data, 16'h00FF);
        step("idle2");
        set_in(1'b1, 16'hC0C0, 1'b1, 16'hD0D0, 1'b1);
        #1;
        chk("prio.rdy0", in0_ready, 1'b1);
        chk("prio.rdy1", in1_ready, 1'b0);
        step("prio_both");

        // Randomized traffic, with an occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                   16'($urandom), 1'($urandom_range(0, 3) != 0));
            if (i == 200) async_reset("rand_rst");
            else step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_mux2_stage.md
# rr_mux2_stage

Registered two-input round-robin arbitration stage that sits directly upstream of the 2:1 datapath mux consumers. It merges two WIDTH-bit valid/ready streams onto one output stream. It generates the select internally, with fair alternation when both sources contend. It provides one register of buffering, so the output is registered and the source that won is reported alongside the data.

## Interface
- WIDTH, 16, data width of both inputs and the output
- clk  input  1  rising-edge clock, the only clock
- reset_n  input  1  asynchronous, active-low reset
- in0_data  input  WIDTH  source 0 payload
- in0_valid  input  1  source 0 has a word
- in0_ready  output  1  source 0 word accepted this cycle when high with in0_valid
- in1_data  input  WIDTH  source 1 payload
- in1_valid  input  1  source 1 has a word
- in1_ready  output  1  source 1 word accepted this cycle when high with in1_valid
- out_data  output  WIDTH  registered payload
- out_src  output  1  source of out_data: 0 = in0, 1 = in1
- out_valid  output  1  out_data/out_src hold a word
- out_ready  input  1  downstream accepts the word this cycle

## Operation
- Internal state:
  - one output register holding out_data, out_src and out_valid.
  - a 1-bit last_grant pointer.
- Register state is EMPTY when out_valid=0 and FULL when out_valid=1.
- can_load = !out_valid || out_ready. An in-flight word drains and a new word loads in the same cycle.
- Arbitration, evaluated combinationally each cycle when can_load=1:
  - If only in0_valid is high, grant 0.
  - If only in1_valid is high, grant 1.
  - If both are high, grant !last_grant.
  - If neither is high, there is no grant.
- in0_ready = can_load && grant==0 && in0_valid-qualified grant; in1_ready is defined the same way for grant 1.
  - A ready may depend combinationally on the other source's valid.
  - A ready never depends on its own data.
- Ready rules:
  - Neither ready is asserted when can_load=0.
  - At most one ready is high per cycle.
- On a transfer from source s at a clock edge:
  - out_data <= ins_data
  - out_src <= s
  - out_valid <= 1
  - last_grant <= s
- If out_valid && out_ready and there is no grant, out_valid <= 0. out_data and out_src keep their values.
- last_grant changes only on a transfer. Idle cycles and stall cycles do not alter the priority.
- A source held valid while stalled keeps its data stable. The block does not latch a word that was not handshaken.

## Timing
- Reset, asynchronous on reset_n=0:
  - out_valid=0, out_data=0, out_src=0
  - last_grant=1, so in0 wins the first contention
  - in0_ready=in1_ready=0 while reset_n=0
- Latency: a word handshaken at edge N appears on out_data/out_valid immediately after edge N, i.e. one cycle.
- Throughput: one word per cycle while out_ready=1 and any source is valid.
- Contention under continuous out_ready=1 with both valid gives grants 0,1,0,1,… in strict alternation.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_src stay frozen
  - both readies are 0
- Reset mid-operation: a word held in the output register is discarded with no partial state. The first post-reset contention again grants in0.
- Release of reset_n is assumed synchronous to clk at the system level. The block does not synchronise it.

## Test plan
- Reset: assert reset_n=0 mid-burst with out_valid=1 -> out_valid=0, out_data=16'h0000, out_src=0 asynchronously, before the next clk edge; both readies 0.
- Single source: in0_valid=1, in0_data=16'hA5A5, in1_valid=0, out_ready=1 -> in0_ready=1; the next cycle shows out_data=16'hA5A5, out_src=0, out_valid=1.
- Contention: both valid continuously, in0_data=16'h1111, in1_data=16'h2222, out_ready=1 for 4 cycles after reset -> out_src sequence 0,1,0,1 with matching data; each ready high on alternate cycles.
- Backpressure: output FULL with 16'hBEEF and out_ready=0 for 3 cycles while both sources valid -> out_data stays 16'hBEEF and both readies stay 0. Dropping out_ready to 1 then loads the next winner in the same cycle.
- Priority retention: grant in1 (word 16'h00FF), then 2 idle cycles, then both valid -> in0 granted first. The idle cycles do not change last_grant.
- Drain to empty: out_valid=1, out_ready=1, no source valid -> out_valid=0 the next cycle; out_data holds its last value.
